// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the CNN datapath stages
// (padder, convolution, pooling).
package cnn_pkg;

    localparam int DATA_W = 32;
    localparam int ACC_W  = 64;

    typedef logic signed [DATA_W-1:0] word_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    function automatic int conv_out_size(input int in_size, input int f, input int s);
        return (in_size - f) / s + 1;
    endfunction

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Single signed 32x32 multiply with a 64-bit registered accumulator.
// clear has priority over en; the product is full width, never truncated.
module conv_mac_unit
    import cnn_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clear_i,
    input  logic  en_i,
    input  word_t a_i,
    input  word_t b_i,
    output acc_t  acc_o
);

    acc_t prod;
    acc_t acc_q;
    acc_t acc_d;

    assign prod = acc_t'(a_i) * acc_t'(b_i);

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + prod;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/conv_window_mac.sv
// Sliding-window convolution over a snapshot of the padded feature map,
// one sequential MAC per window, results streamed in raster order.
//
// state  | meaning
// IDLE   | waiting for start; snapshot inputs on start
// MAC    | one kernel tap accumulated per cycle, kc fastest
// OUT    | window result presented, held until out_ready
// DONE   | one-cycle done pulse, then back to IDLE
module conv_window_mac
    import cnn_pkg::*;
#(
    parameter  int IN_SIZE     = 6,
    parameter  int FILTER_SIZE = 3,
    parameter  int STRIDE      = 1,
    localparam int OUT_SIZE    = conv_out_size(IN_SIZE, FILTER_SIZE, STRIDE),
    localparam int IDX_W       = idx_width(OUT_SIZE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  word_t            in_array [IN_SIZE][IN_SIZE],
    input  word_t            kernel   [FILTER_SIZE][FILTER_SIZE],
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output word_t            out_data,
    output logic [IDX_W-1:0] out_row,
    output logic [IDX_W-1:0] out_col,
    output logic             done
);

    localparam int KW = idx_width(FILTER_SIZE);
    localparam int RW = idx_width(IN_SIZE);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [KW-1:0]    K_LAST = KW'(FILTER_SIZE - 1);
    localparam logic [IDX_W-1:0] O_LAST = IDX_W'(OUT_SIZE - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] wr_q, wr_d;
    logic [IDX_W-1:0] wc_q, wc_d;
    logic [KW-1:0]    kr_q, kr_d;
    logic [KW-1:0]    kc_q, kc_d;

    word_t in_q [IN_SIZE][IN_SIZE];
    word_t k_q  [FILTER_SIZE][FILTER_SIZE];

    logic          snap_en;
    logic          mac_clear;
    logic          mac_en;
    logic [RW-1:0] row_idx;
    logic [RW-1:0] col_idx;
    word_t         mac_a;
    word_t         mac_b;
    acc_t          acc;
    logic          unused_acc_hi;

    assign row_idx = RW'(wr_q) * RW'(STRIDE) + RW'(kr_q);
    assign col_idx = RW'(wc_q) * RW'(STRIDE) + RW'(kc_q);
    assign mac_a   = in_q[row_idx][col_idx];
    assign mac_b   = k_q[kr_q][kc_q];

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        wc_d      = wc_q;
        kr_d      = kr_q;
        kc_d      = kc_q;
        snap_en   = 1'b0;
        mac_clear = 1'b0;
        mac_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_en   = 1'b1;
                    mac_clear = 1'b1;
                    wr_d      = '0;
                    wc_d      = '0;
                    kr_d      = '0;
                    kc_d      = '0;
                    state_d   = S_MAC;
                end
            end
            S_MAC: begin
                mac_en = 1'b1;
                if (kc_q == K_LAST) begin
                    kc_d = '0;
                    if (kr_q == K_LAST) begin
                        kr_d    = '0;
                        state_d = S_OUT;
                    end else begin
                        kr_d = kr_q + 1'b1;
                    end
                end else begin
                    kc_d = kc_q + 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (wr_q == O_LAST && wc_q == O_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        mac_clear = 1'b1;
                        kr_d      = '0;
                        kc_d      = '0;
                        if (wc_q == O_LAST) begin
                            wc_d = '0;
                            wr_d = wr_q + 1'b1;
                        end else begin
                            wc_d = wc_q + 1'b1;
                        end
                        state_d = S_MAC;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wr_q    <= '0;
            wc_q    <= '0;
            kr_q    <= '0;
            kc_q    <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            wc_q    <= wc_d;
            kr_q    <= kr_d;
            kc_q    <= kc_d;
        end
    end

    // Snapshot storage is data only; it is always rewritten before use.
    always_ff @(posedge clk) begin
        if (snap_en) begin
            in_q <= in_array;
            k_q  <= kernel;
        end
    end

    conv_mac_unit u_mac (
        .clk     (clk),
        .reset   (reset),
        .clear_i (mac_clear),
        .en_i    (mac_en),
        .a_i     (mac_a),
        .b_i     (mac_b),
        .acc_o   (acc)
    );

    assign unused_acc_hi = ^acc[ACC_W-1:DATA_W];

    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign done      = (state_q == S_DONE);
    assign out_data  = word_t'(acc[DATA_W-1:0]);
    assign out_row   = wr_q;
    assign out_col   = wc_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench for conv_window_mac with hand-computed window sums.
module tb_conv_window_mac;
    import cnn_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    word_t      in_array [6][6];
    word_t      kernel   [3][3];
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    word_t      out_data;
    logic [1:0] out_row;
    logic [1:0] out_col;
    logic       done;

    word_t exp_q [4][4];
    int    n_checks = 0;
    int    n_errors = 0;

    always #5 clk = ~clk;

    conv_window_mac dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_array  (in_array),
        .kernel    (kernel),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .done      (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_in(input word_t v);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                in_array[r][c] = v;
    endtask

    task automatic fill_k(input word_t v, input word_t centre);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                kernel[r][c] = v;
        kernel[1][1] = centre;
    endtask

    task automatic fill_exp(input word_t v);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                exp_q[r][c] = v;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Drives out_ready and checks every presented window against exp_q.
    task automatic run_frame(input int stall_idx, input int stop_idx,
                             input bit start_at_end, output int span);
        int idx, stall, cyc, first_c, last_c, r, c;
        idx = 0; stall = 0; cyc = 0; first_c = 0; last_c = 0;
        while (idx < stop_idx && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            r = idx / 4;
            c = idx % 4;
            if (!out_valid) begin
                out_ready = cyc[0];
            end else if (idx == stall_idx && stall < 5) begin
                out_ready = 1'b0;
                stall++;
                check($sformatf("stall_data[%0d]", idx), out_data, exp_q[r][c]);
                check($sformatf("stall_pos[%0d]", idx), {out_row, out_col}, {r[1:0], c[1:0]});
            end else begin
                out_ready = 1'b1;
                check($sformatf("data[%0d][%0d]", r, c), out_data, exp_q[r][c]);
                check($sformatf("pos[%0d]", idx), {out_row, out_col}, {r[1:0], c[1:0]});
                if (idx == 0) first_c = cyc;
                last_c = cyc;
                if (start_at_end && idx == stop_idx - 1) start = 1'b1;
                idx++;
            end
        end
        if (idx < stop_idx) check("frame_timeout", idx, stop_idx);
        span = last_c - first_c;
    endtask

    task automatic finish_frame();
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b1;
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        @(negedge clk);
        check("done_low", done, 0);
        check("busy_after_done", busy, 0);
        @(negedge clk);
        check("idle_stays", busy, 0);
    endtask

    initial begin
        int span, seen;
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        fill_in(32'sd0);
        fill_k(32'sd0, 32'sd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_pos", {out_row, out_col}, 4'd0);
        check("rst_done", done, 0);

        // All ones: every window sums to 9; latency and throughput checked.
        fill_in(32'sd1);
        fill_k(32'sd1, 32'sd1);
        fill_exp(32'sd9);
        do_start();
        check("busy_after_start", busy, 1);
        repeat (8) @(posedge clk);
        #1;
        check("valid_cycle9", out_valid, 0);
        @(posedge clk);
        #1;
        check("valid_cycle10", out_valid, 1);
        run_frame(-1, 16, 1'b1, span);
        check("window_period", span, 150);
        finish_frame();

        // Identity kernel with backpressure on window (1,2).
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                in_array[r][c] = word_t'(r * 6 + c);
        fill_k(32'sd0, 32'sd1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                exp_q[r][c] = word_t'((r + 1) * 6 + (c + 1));
        check("exp_00", exp_q[0][0], 7);
        check("exp_33", exp_q[3][3], 28);
        do_start();
        run_frame(6, 16, 1'b0, span);
        finish_frame();

        // Inputs change and start re-pulses mid-frame; snapshot must win.
        do_start();
        @(negedge clk);
        fill_in(32'sd1000);
        fill_k(32'sd7, 32'sd7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_frame(-1, 16, 1'b0, span);
        finish_frame();

        // Signed: -1 * 2 over nine taps = -18.
        fill_in(-32'sd1);
        fill_k(32'sd2, 32'sd2);
        fill_exp(word_t'(32'hFFFFFFEE));
        do_start();
        run_frame(-1, 16, 1'b0, span);
        finish_frame();

        // 0x7FFFFFFF * 2 keeps only its low 32 bits.
        fill_in(word_t'(32'h7FFFFFFF));
        fill_k(32'sd0, 32'sd2);
        fill_exp(word_t'(32'hFFFFFFFE));
        do_start();
        run_frame(-1, 16, 1'b0, span);
        finish_frame();

        // Reset during the MAC phase of window (2,0).
        fill_in(-32'sd1);
        fill_k(32'sd2, 32'sd2);
        fill_exp(word_t'(32'hFFFFFFEE));
        do_start();
        run_frame(-1, 8, 1'b0, span);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_done", done, 0);
        reset = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || out_valid) seen++;
        end
        check("no_done_after_rst", seen, 0);

        fill_in(32'sd1);
        fill_k(32'sd1, 32'sd1);
        fill_exp(32'sd9);
        do_start();
        run_frame(-1, 16, 1'b0, span);
        finish_frame();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
